// File: rtl/bsg_axi_pkg.sv
// Shared AXI/AXIS definitions for the Zynq shell blocks.
//   e_axis_unpack_state : state of the AXIS beat unpacker
//     e_empty - no buffered beat, slave port ready
//     e_drain - buffered beat still has words to deliver
package bsg_axi_pkg;

    typedef enum logic [0:0] {
        e_empty = 1'b0,
        e_drain = 1'b1
    } e_axis_unpack_state;

endpackage

// File: rtl/bsg_priority_encode.sv
// One-hot priority encoder.
//   bits_i   : request vector
//   onehot_o : one-hot of the winning request (all zero when bits_i == 0)
// lo_to_hi_p = 1 gives priority to the lowest set bit, otherwise the highest.
module bsg_priority_encode #(
    parameter int unsigned width_p    = 2,
    parameter bit          lo_to_hi_p = 1'b1
) (
    input  logic [width_p-1:0] bits_i,
    output logic [width_p-1:0] onehot_o
);

    // Scan towards the preferred end so the last hit written is the winner.
    always_comb begin
        onehot_o = '0;
        if (lo_to_hi_p) begin
            for (int k = int'(width_p) - 1; k >= 0; k--) begin
                if (bits_i[k]) begin
                    onehot_o    = '0;
                    onehot_o[k] = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < int'(width_p); k++) begin
                if (bits_i[k]) begin
                    onehot_o    = '0;
                    onehot_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_axis_beat_unpacker.sv
// AXI4-Stream slave that buffers one wide beat and replays it as narrow words on a
// valid/ready port, skipping words whose keep bytes are all clear.
//   clk_i, reset_n_i          : clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tkeep/tlast : AXIS slave beat port
//   v_o, ready_i, data_o, last_o : word output port (last_o marks the packet's last word)
//   err_o                     : sticky protocol error (partial word, or empty beat with tlast)
module bsg_axis_beat_unpacker
    import bsg_axi_pkg::*;
#(
    parameter int unsigned axis_data_width_p = 64,
    parameter int unsigned word_width_p      = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             s_axis_tvalid_i,
    output logic                             s_axis_tready_o,
    input  logic [axis_data_width_p-1:0]     s_axis_tdata_i,
    input  logic [(axis_data_width_p>>3)-1:0] s_axis_tkeep_i,
    input  logic                             s_axis_tlast_i,
    output logic                             v_o,
    input  logic                             ready_i,
    output logic [word_width_p-1:0]          data_o,
    output logic                             last_o,
    output logic                             err_o
);

    localparam int unsigned words_per_beat_lp  = axis_data_width_p / word_width_p;
    localparam int unsigned axis_mask_width_lp = axis_data_width_p >> 3;
    localparam int unsigned word_bytes_lp      = word_width_p >> 3;

    e_axis_unpack_state             state_q;
    logic [axis_data_width_p-1:0]   data_q;
    logic [words_per_beat_lp-1:0]   mask_q;
    logic                           last_q;
    logic                           err_q;
    // Holds tready low until the first clock after reset release.
    logic                           live_q;

    logic [words_per_beat_lp-1:0]   in_mask;
    logic [words_per_beat_lp-1:0]   in_partial;
    logic [words_per_beat_lp-1:0]   sel_onehot;
    logic [words_per_beat_lp-1:0]   mask_rest;
    logic                           final_word;
    logic                           out_hs;
    logic                           accept;
    logic                           in_err;

    // A word is present if any of its keep bytes is set; partial if only some are.
    for (genvar k = 0; k < int'(words_per_beat_lp); k++) begin : g_word
        assign in_mask[k]    = |s_axis_tkeep_i[k*word_bytes_lp +: word_bytes_lp];
        assign in_partial[k] = in_mask[k] & ~(&s_axis_tkeep_i[k*word_bytes_lp +: word_bytes_lp]);
    end

    bsg_priority_encode #(
        .width_p    (words_per_beat_lp),
        .lo_to_hi_p (1'b1)
    ) u_sel (
        .bits_i   (mask_q),
        .onehot_o (sel_onehot)
    );

    assign mask_rest  = mask_q & ~sel_onehot;
    assign final_word = (mask_rest == '0);
    assign v_o        = (state_q == e_drain);
    assign out_hs     = v_o & ready_i;
    // Ready again in the cycle the last buffered word handshakes: one word per cycle sustained.
    assign s_axis_tready_o = live_q & ((state_q == e_empty) | (out_hs & final_word));
    assign accept     = s_axis_tvalid_i & s_axis_tready_o;
    assign in_err     = (|in_partial) | (~(|in_mask) & s_axis_tlast_i);
    assign last_o     = v_o & last_q & final_word;
    assign err_o      = err_q;

    // One-hot word mux; reads zero whenever no word is buffered.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < int'(words_per_beat_lp); k++) begin
            if (sel_onehot[k]) begin
                data_o = data_o | data_q[k*word_width_p +: word_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_empty;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                data_q  <= s_axis_tdata_i;
                mask_q  <= in_mask;
                last_q  <= s_axis_tlast_i;
                // An all-empty beat is dropped without leaving e_empty.
                state_q <= (|in_mask) ? e_drain : e_empty;
                if (in_err) begin
                    err_q <= 1'b1;
                end
            end else if (out_hs) begin
                mask_q <= mask_rest;
                if (final_word) begin
                    state_q <= e_empty;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_axis_beat_unpacker.sv
module tb_bsg_axis_beat_unpacker;

    localparam int DW  = 64;
    localparam int WW  = 32;
    localparam int MW  = DW / 8;
    localparam int WB  = WW / 8;
    localparam int WPB = DW / WW;

    typedef struct {
        logic [WW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [MW-1:0] tkeep;
    logic          tlast;
    logic          v;
    logic          ready;
    logic [WW-1:0] data;
    logic          last;
    logic          err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   hs_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic err_exp;
    int   rdy_mode;
    logic rdy_manual;
    logic rdy_rand = 1'b1;

    always #5 clk = ~clk;

    assign ready = (rdy_mode == 1) ? rdy_rand : rdy_manual;

    bsg_axis_beat_unpacker #(
        .axis_data_width_p (DW),
        .word_width_p      (WW)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tready_o (tready),
        .s_axis_tdata_i  (tdata),
        .s_axis_tkeep_i  (tkeep),
        .s_axis_tlast_i  (tlast),
        .v_o             (v),
        .ready_i         (ready),
        .data_o          (data),
        .last_o          (last),
        .err_o           (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    // Monitor: every output handshake consumes the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && v && ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", data);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", 64'(data), 64'(mon_e.d));
                check("word_last", 64'(last), 64'(mon_e.l));
            end
        end
    end

    // Reference: kept words in index order, last flag on the highest kept word of a tlast beat.
    task automatic model_beat(input logic [DW-1:0] d, input logic [MW-1:0] k, input logic l);
        int   kept[$];
        int   nset;
        bit   partial;
        exp_t e;
        partial = 0;
        for (int w = 0; w < WPB; w++) begin
            nset = 0;
            for (int b = 0; b < WB; b++) begin
                if (k[w*WB+b]) nset++;
            end
            if (nset > 0) kept.push_back(w);
            if (nset > 0 && nset < WB) partial = 1;
        end
        for (int i = 0; i < kept.size(); i++) begin
            e.d = d[kept[i]*WW +: WW];
            e.l = l && (i == kept.size() - 1);
            exp_q.push_back(e);
        end
        if (partial || (kept.size() == 0 && l)) err_exp = 1'b1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] k, input logic l);
        int waited;
        waited = 0;
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        @(negedge clk);
        while (!tready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!tready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=tready_low required=accept");
        end else begin
            acc_cyc = cyc;
            model_beat(d, k, l);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || v) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tvalid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_v", 64'(v), 64'd0);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        exp_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            b2;
        int            n;
        bit            sawv;
        logic [DW-1:0] rd;
        logic [MW-1:0] rk;
        tvalid = 1'b0;
        tdata  = '0;
        tkeep  = '0;
        tlast  = 1'b0;
        rdy_mode   = 0;
        rdy_manual = 1'b1;
        err_exp    = 1'b0;
        #2;
        do_reset();
        check("tready_after_reset", 64'(tready), 64'd1);

        // Full beat, two words in order.
        send_beat(64'hBBBB_BBBB_AAAA_AAAA, 8'hFF, 1'b1);
        wait_drain();
        check("full_beat_err", 64'(err), 64'(err_exp));

        // Sparse beat; next beat accepted in the sparse word's handshake cycle.
        base = hs_cyc.size();
        send_beat(64'h1234_5678_DEAD_BEEF, 8'hF0, 1'b0);
        send_beat(64'h0BAD_F00D_CAFE_0001, 8'hFF, 1'b1);
        b2 = acc_cyc;
        wait_drain();
        if (hs_cyc.size() > base) check("sparse_overlap_cycle", 64'(b2), 64'(hs_cyc[base]));
        else check("sparse_word_seen", 64'(hs_cyc.size()), 64'(base + 1));

        // Back-to-back full beats at one word per cycle.
        base = hs_cyc.size();
        for (int i = 0; i < 8; i++) begin
            rd = {$urandom(), $urandom()};
            send_beat(rd, 8'hFF, 1'(i == 7));
        end
        wait_drain();
        check("b2b_word_count", 64'(hs_cyc.size() - base), 64'd16);
        if (hs_cyc.size() >= base + 16)
            check("b2b_span", 64'(hs_cyc[base+15] - hs_cyc[base]), 64'd15);

        // Back-pressure: first word must hold steady while ready is low.
        rdy_mode   = 2;
        rdy_manual = 1'b0;
        send_beat(64'h2222_2222_1111_1111, 8'hFF, 1'b1);
        n = 0;
        @(negedge clk);
        while (!v && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_v_held", 64'(v), 64'd1);
            check("bp_data_stable", 64'(data), 64'h1111_1111);
            check("bp_last_stable", 64'(last), 64'd0);
            check("bp_tready_low", 64'(tready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        wait_drain();

        // 100-beat random packet with random back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            rd = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       rk = 8'hFF;
                1:       rk = 8'h0F;
                2:       rk = 8'hF0;
                default: rk = 8'($urandom());
            endcase
            send_beat(rd, rk, 1'(i == 99));
        end
        wait_drain();
        check("random_err", 64'(err), 64'(err_exp));

        // Null beat with tlast: dropped, error raised.
        rdy_mode   = 0;
        rdy_manual = 1'b1;
        do_reset();
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1);
        sawv = 0;
        repeat (5) begin
            @(negedge clk);
            if (v) sawv = 1;
        end
        check("null_no_word", 64'(sawv), 64'd0);
        check("null_err", 64'(err), 64'd1);
        @(posedge clk);
        #1;

        // Partial word: emitted whole, error raised.
        do_reset();
        send_beat(64'h7777_6666_5555_4444, 8'h1F, 1'b1);
        wait_drain();
        check("partial_err", 64'(err), 64'd1);

        // Async reset in the middle of draining a beat.
        do_reset();
        rdy_mode   = 2;
        rdy_manual = 1'b0;
        send_beat(64'h9999_9999_8888_8888, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        @(posedge clk);
        #1;
        rdy_manual = 1'b0;
        check("mid_second_word", 64'(data), 64'h9999_9999);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_v", 64'(v), 64'd0);
        check("mid_rst_tready", 64'(tready), 64'd0);
        exp_q.delete();
        err_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        rdy_manual = 1'b1;
        sawv = 0;
        repeat (4) begin
            @(negedge clk);
            if (v) sawv = 1;
        end
        check("mid_no_stale", 64'(sawv), 64'd0);
        check("mid_tready_up", 64'(tready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
